// File: rtl/tnoc_output_port_scheduler.sv
// Packet-level round-robin scheduler for one router output port: the grant is
// locked to the winning channel from head flit to tail flit.
module tnoc_output_port_scheduler #(
    parameter int REQUESTERS  = 5,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [REQUESTERS-1:0]  i_request,
    input  logic [REQUESTERS-1:0]  i_start_of_packet,
    input  logic [REQUESTERS-1:0]  i_end_of_packet,
    output logic [REQUESTERS-1:0]  o_grant,
    output logic                   o_busy,
    output logic [COUNT_WIDTH-1:0] o_packet_count,
    output logic                   o_protocol_error
);

    localparam int PTR_W = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;

    localparam logic STATE_IDLE   = 1'b0;
    localparam logic STATE_LOCKED = 1'b1;

    logic                   state_q, state_d;
    logic [REQUESTERS-1:0]  grant_q, grant_d;
    logic                   busy_q, busy_d;
    logic [PTR_W-1:0]       ptr_q, ptr_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic                   error_q, error_d;

    logic [REQUESTERS-1:0]  eligible;
    logic [REQUESTERS-1:0]  winner;
    logic [PTR_W-1:0]       grant_idx;
    logic [PTR_W-1:0]       ptr_after_grant;
    logic                   granted_eop;
    logic                   multi_eop;

    // Scanning from the far end and overwriting leaves the first eligible
    // index at or after ptr (with wrap) as the only bit set.
    function automatic logic [REQUESTERS-1:0] rr_pick(
        input logic [REQUESTERS-1:0] elig,
        input logic [PTR_W-1:0]      ptr
    );
        logic [REQUESTERS-1:0] pick;
        logic [PTR_W-1:0]      idx;
        pick = '0;
        for (int k = REQUESTERS - 1; k >= 0; k--) begin
            idx = PTR_W'((int'(ptr) + k) % REQUESTERS);
            if (elig[idx]) begin
                pick      = '0;
                pick[idx] = 1'b1;
            end
        end
        return pick;
    endfunction

    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < REQUESTERS; i++) begin
            if (grant_q[i]) begin
                grant_idx = grant_idx | PTR_W'(i);
            end
        end
    end

    assign ptr_after_grant = (grant_idx == PTR_W'(REQUESTERS - 1)) ? '0 : grant_idx + 1'b1;
    assign eligible        = i_request & i_start_of_packet;
    assign granted_eop     = |(i_end_of_packet & grant_q);
    assign multi_eop       = (i_end_of_packet & (i_end_of_packet - 1'b1)) != '0;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        busy_d  = busy_q;
        ptr_d   = ptr_q;
        count_d = count_q;
        winner  = '0;
        // Any tail outside the current grant (all of them while idle) is illegal.
        error_d = error_q | (|(i_end_of_packet & ~grant_q)) | multi_eop;

        case (state_q)
            STATE_IDLE: begin
                winner = rr_pick(eligible, ptr_q);
                if (|winner) begin
                    grant_d = winner;
                    busy_d  = 1'b1;
                    state_d = STATE_LOCKED;
                end
            end
            STATE_LOCKED: begin
                if (granted_eop) begin
                    count_d = count_q + COUNT_WIDTH'(1);
                    ptr_d   = ptr_after_grant;
                    // Hand over in the same cycle so packets run back to back.
                    winner  = rr_pick(eligible & ~grant_q, ptr_after_grant);
                    grant_d = winner;
                    busy_d  = |winner;
                    state_d = (|winner) ? STATE_LOCKED : STATE_IDLE;
                end
            end
            default: begin
                state_d = STATE_IDLE;
                grant_d = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= STATE_IDLE;
            grant_q <= '0;
            busy_q  <= 1'b0;
            ptr_q   <= '0;
            count_q <= '0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            busy_q  <= busy_d;
            ptr_q   <= ptr_d;
            count_q <= count_d;
            error_q <= error_d;
        end
    end

    assign o_grant          = grant_q;
    assign o_busy           = busy_q;
    assign o_packet_count   = count_q;
    assign o_protocol_error = error_q;

endmodule

// File: tb/tb_tnoc_output_port_scheduler.sv
// Bench for tnoc_output_port_scheduler: directed scenarios plus randomized
// traffic compared against an owner/pointer reference model.
module tb_tnoc_output_port_scheduler;

    localparam int R  = 5;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [R-1:0]  req = '0;
    logic [R-1:0]  sop = '0;
    logic [R-1:0]  eop = '0;
    logic [R-1:0]  grant;
    logic          busy;
    logic [CW-1:0] count;
    logic          err;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: which requester owns the port (-1 = nobody).
    int            m_owner = -1;
    int            m_ptr   = 0;
    logic [CW-1:0] m_count = '0;
    logic          m_err   = 1'b0;

    logic [R-1:0] exp_q[$];

    tnoc_output_port_scheduler #(
        .REQUESTERS (R),
        .COUNT_WIDTH(CW)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .i_request        (req),
        .i_start_of_packet(sop),
        .i_end_of_packet  (eop),
        .o_grant          (grant),
        .o_busy           (busy),
        .o_packet_count   (count),
        .o_protocol_error (err)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int rr_pick(input logic [R-1:0] elig, input int ptr);
        for (int k = 0; k < R; k++) begin
            if (elig[(ptr + k) % R]) return (ptr + k) % R;
        end
        return -1;
    endfunction

    function automatic logic [R-1:0] exp_grant();
        return (m_owner < 0) ? '0 : R'(1 << m_owner);
    endfunction

    task automatic model_step();
        logic [R-1:0] elig;
        if (rst) begin
            m_owner = -1;
            m_ptr   = 0;
            m_count = '0;
            m_err   = 1'b0;
            return;
        end
        if ($countones(eop) > 1) m_err = 1'b1;
        for (int i = 0; i < R; i++) begin
            if (eop[i] && i != m_owner) m_err = 1'b1;
        end
        elig = req & sop;
        if (m_owner < 0) begin
            m_owner = rr_pick(elig, m_ptr);
        end else if (eop[m_owner]) begin
            m_count       = m_count + 1'b1;
            m_ptr         = (m_owner + 1) % R;
            elig[m_owner] = 1'b0;
            m_owner       = rr_pick(elig, m_ptr);
        end
    endtask

    // Inputs are stable here; model and DUT both consume them at the edge.
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        sop = '0;
        eop = '0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            req = R'($urandom);
            sop = R'($urandom);
            eop = R'($urandom);
            tick();
            n_vec++;
            if (grant !== '0 || busy !== 1'b0 || count !== '0 || err !== 1'b0) begin
                n_err++;
                $display("FAIL reset[%0d]: grant=%b busy=%b count=%0d err=%b, required 0 0 0 0",
                         c, grant, busy, count, err);
            end
        end
        do_reset();
    endtask

    task automatic test_single();
        do_reset();
        req = 5'b00100;
        sop = 5'b00100;
        tick();
        sop = '0;
        n_vec++;
        if (grant !== 5'b00100 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL single_grant: grant=%b busy=%b, required 00100 1", grant, busy);
        end
        for (int c = 0; c < 3; c++) begin
            tick();
            n_vec++;
            if (grant !== 5'b00100) begin
                n_err++;
                $display("FAIL single_hold[%0d]: grant=%b, required 00100", c, grant);
            end
        end
        eop = 5'b00100;
        tick();
        eop = '0;
        req = '0;
        n_vec++;
        if (grant !== '0 || busy !== 1'b0 || count !== 4'd1 || err !== 1'b0) begin
            n_err++;
            $display("FAIL single_end: grant=%b busy=%b count=%0d err=%b, required 00000 0 1 0",
                     grant, busy, count, err);
        end
        // Pointer now sits at 3, so requester 3 beats requester 0.
        req = 5'b01001;
        sop = 5'b01001;
        tick();
        req = '0;
        sop = '0;
        n_vec++;
        if (grant !== 5'b01000) begin
            n_err++;
            $display("FAIL single_pointer: grant=%b, required 01000", grant);
        end
        eop = 5'b01000;
        tick();
        eop = '0;
        n_vec++;
        if (grant !== '0 || count !== 4'd2) begin
            n_err++;
            $display("FAIL single_second_end: grant=%b count=%0d, required 00000 2", grant, count);
        end
    endtask

    task automatic test_back_to_back();
        int           flit[R];
        int           eops_sent;
        int           idle_cycles;
        int           owner_now;
        logic         started;
        logic [R-1:0] prev_grant;
        logic [R-1:0] got;
        do_reset();
        for (int i = 0; i < R; i++) flit[i] = 0;
        exp_q       = {5'b00001, 5'b00010, 5'b10000, 5'b00001, 5'b00010, 5'b10000};
        eops_sent   = 0;
        idle_cycles = 0;
        started     = 1'b0;
        prev_grant  = '0;
        for (int cyc = 0; cyc < 60 && eops_sent < 6; cyc++) begin
            owner_now = m_owner;
            eop = '0;
            if (owner_now >= 0 && flit[owner_now] == 2) eop[owner_now] = 1'b1;
            req = ((eops_sent + ((eop != '0) ? 1 : 0)) >= 6) ? '0 : 5'b10011;
            for (int i = 0; i < R; i++) sop[i] = req[i] && (flit[i] == 0);
            tick();
            if (owner_now >= 0) flit[owner_now] = (flit[owner_now] + 1) % 3;
            if (eop != '0) eops_sent++;
            if (grant != '0 && grant != prev_grant) begin
                started = 1'b1;
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL b2b_order: grant=%b, required no further grant", grant);
                end else begin
                    got = exp_q.pop_front();
                    if (grant !== got) begin
                        n_err++;
                        $display("FAIL b2b_order: grant=%b, required %b", grant, got);
                    end
                end
            end else if (started && grant == '0 && eops_sent < 6) begin
                idle_cycles++;
            end
            prev_grant = grant;
        end
        req = '0;
        sop = '0;
        eop = '0;
        n_vec++;
        if (exp_q.size() != 0 || idle_cycles != 0 || eops_sent != 6) begin
            n_err++;
            $display("FAIL b2b_flow: grants_left=%0d idle=%0d eops=%0d, required 0 0 6",
                     exp_q.size(), idle_cycles, eops_sent);
        end
        n_vec++;
        if (count !== 4'd6 || grant !== '0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_count: count=%0d grant=%b busy=%b, required 6 00000 0", count, grant, busy);
        end
    endtask

    task automatic test_lock();
        do_reset();
        req = 5'b01000;
        sop = 5'b01000;
        tick();
        req = 5'b01010;
        sop = 5'b00010;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_vec++;
            if (grant !== 5'b01000) begin
                n_err++;
                $display("FAIL lock_hold[%0d]: grant=%b, required 01000", c, grant);
            end
        end
        eop = 5'b01000;
        tick();
        eop = '0;
        req = 5'b00010;
        sop = '0;
        n_vec++;
        if (grant !== 5'b00010 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL lock_handover: grant=%b busy=%b, required 00010 1", grant, busy);
        end
        req = '0;
        eop = 5'b00010;
        tick();
        eop = '0;
        n_vec++;
        if (grant !== '0 || count !== 4'd2 || err !== 1'b0) begin
            n_err++;
            $display("FAIL lock_end: grant=%b count=%0d err=%b, required 00000 2 0", grant, count, err);
        end
    endtask

    task automatic test_error();
        do_reset();
        req = 5'b00100;
        sop = 5'b00100;
        tick();
        sop = '0;
        n_vec++;
        if (err !== 1'b0) begin
            n_err++;
            $display("FAIL error_clean: err=%b, required 0", err);
        end
        eop = 5'b00001;
        tick();
        eop = '0;
        for (int c = 0; c < 3; c++) begin
            n_vec++;
            if (err !== 1'b1 || grant !== 5'b00100) begin
                n_err++;
                $display("FAIL error_sticky[%0d]: err=%b grant=%b, required 1 00100", c, err, grant);
            end
            tick();
        end
        eop = 5'b00100;
        req = '0;
        tick();
        eop = '0;
        n_vec++;
        if (err !== 1'b1 || grant !== '0 || count !== 4'd1) begin
            n_err++;
            $display("FAIL error_after_end: err=%b grant=%b count=%0d, required 1 00000 1", err, grant, count);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_vec++;
        if (err !== 1'b0) begin
            n_err++;
            $display("FAIL error_clear: err=%b, required 0", err);
        end
    endtask

    task automatic test_wrap();
        int bad;
        do_reset();
        bad = 0;
        for (int p = 0; p < 17; p++) begin
            req = 5'b00010;
            sop = 5'b00010;
            eop = '0;
            tick();
            if (grant !== 5'b00010) bad++;
            eop = 5'b00010;
            tick();
            eop = '0;
            if (grant !== '0) bad++;
        end
        req = '0;
        sop = '0;
        n_vec++;
        if (bad != 0 || count !== 4'd1 || err !== 1'b0) begin
            n_err++;
            $display("FAIL wrap: bad_grants=%0d count=%0d err=%b, required 0 1 0", bad, count, err);
        end
        req = 5'b00010;
        sop = 5'b00010;
        tick();
        sop = '0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req = '0;
        n_vec++;
        if (grant !== '0 || busy !== 1'b0 || count !== '0) begin
            n_err++;
            $display("FAIL mid_reset: grant=%b busy=%b count=%0d, required 00000 0 0", grant, busy, count);
        end
    endtask

    task automatic test_random();
        logic [R-1:0] eg;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            rst = ($urandom_range(0, 99) == 0);
            req = R'($urandom);
            sop = R'($urandom);
            eop = '0;
            if (m_owner >= 0 && $urandom_range(0, 2) == 0) eop[m_owner] = 1'b1;
            if ($urandom_range(0, 59) == 0) eop[$urandom_range(0, R - 1)] = 1'b1;
            tick();
            eg = exp_grant();
            n_vec++;
            if (grant !== eg || busy !== (|eg) || count !== m_count || err !== m_err) begin
                n_err++;
                $display("FAIL random[%0d]: grant=%b busy=%b count=%0d err=%b, required %b %b %0d %b",
                         c, grant, busy, count, err, eg, |eg, m_count, m_err);
            end
        end
        rst = 1'b0;
        req = '0;
        sop = '0;
        eop = '0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_lock();
        test_error();
        test_wrap();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
